sensor_condition: RTL and testbench

Front-end conditioning block for the eBike drive loop. Synchronises the raw cadence pulse, measures cadence, and exponentially averages motor current and pedal torque. Combines averaged torque, incline, cadence and assist scale into a target current, and produces the signed `error` and `not_pedaling` that feed the PID drive-magnitude controller. It is the producer end of the PID's `error`/`not_pedaling` interface.

---
 rtl/sensor_condition.sv | 163 ++++++++++++++++
 tb/tb_sensor_condition.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_condition.sv
// sensor_condition
//   Front end of the eBike drive loop. Synchronises the crank pulse and
//   measures cadence once per window. Keeps exponential averages of motor
//   current and pedal torque. Forms a target current from averaged torque,
//   incline, cadence and assist level, and presents the signed current error
//   and the not-pedaling flag to the downstream PID.
//
// Ports
//   clk          in   50 MHz system clock
//   rst_n        in   synchronous active-low reset
//   cadence_raw  in   raw crank pulse, asynchronous to clk
//   curr         in   [11:0] unsigned motor current sample
//   torque       in   [11:0] unsigned pedal torque sample
//   incline      in   [12:0] signed incline
//   scale        in   [2:0]  assist level 0..7
//   batt         in   [11:0] unsigned battery voltage
//   error        out  [12:0] signed target_curr - avg_curr, registered
//   not_pedaling out  cadence below 2 in the last window, registered
module sensor_condition #(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cadence_raw,
  input  logic        [11:0] curr,
  input  logic        [11:0] torque,
  input  logic signed [12:0] incline,
  input  logic        [2:0]  scale,
  input  logic        [11:0] batt,
  output logic signed [12:0] error,
  output logic               not_pedaling
);

  localparam int WIN_W = FAST_SIM ? 12 : 22;
  localparam int SMP_W = FAST_SIM ? 8 : 16;

  localparam logic [11:0] TORQUE_BASE = 12'h380;
  localparam logic [11:0] BATT_MIN    = 12'hA98;

  // Averaged torque above the dead band, floored at zero.
  function automatic logic [11:0] torque_offset(input logic [11:0] avg_t);
    if (avg_t > TORQUE_BASE) return avg_t - TORQUE_BASE;
    else                     return 12'd0;
  endfunction

  // Incline limited to [-512, 511], biased by 256, then limited to [0, 511].
  function automatic logic [8:0] incline_factor(input logic signed [12:0] incl);
    logic signed [12:0] sat;
    logic signed [12:0] biased;
    if (incl < -13'sd512)     sat = -13'sd512;
    else if (incl > 13'sd511) sat = 13'sd511;
    else                      sat = incl;
    biased = sat + 13'sd256;
    if (biased < 13'sd0)        return 9'd0;
    else if (biased > 13'sd511) return 9'd511;
    else                        return biased[8:0];
  endfunction

  // Product scaled by 2^-15; anything that overflows 12 bits pins to full scale.
  function automatic logic [11:0] target_sat(input logic [29:0] p);
    if (|p[29:27]) return 12'hFFF;
    else           return p[26:15];
  endfunction

  logic [2:0]       sync_q, sync_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [4:0]       edge_q, edge_d;
  logic [4:0]       cadence_q, cadence_d;
  logic             not_pedaling_q, not_pedaling_d;
  logic [SMP_W-1:0] smp_q, smp_d;
  logic [13:0]      curr_acc_q, curr_acc_d;
  logic [16:0]      torq_acc_q, torq_acc_d;
  logic [29:0]      prod_q, prod_d;
  logic signed [12:0] error_q, error_d;

  logic        cad_rise;
  logic        win_end;
  logic        smpl;
  logic [11:0] avg_curr;
  logic [11:0] avg_torque;
  logic [11:0] torque_off;
  logic [8:0]  incl_fac;
  logic [5:0]  cad_fac;
  logic [11:0] target_curr;
  logic        batt_low;

  always_comb begin
    // Input synchroniser; rise taken between the second and third stage.
    sync_d   = {sync_q[1:0], cadence_raw};
    cad_rise = sync_q[1] & ~sync_q[2];

    // Cadence window. A rise landing on the terminal cycle belongs to the
    // next window, so the fresh count starts at 1 rather than 0.
    win_d          = win_q + 1'b1;
    win_end        = &win_q;
    edge_d         = edge_q;
    cadence_d      = cadence_q;
    not_pedaling_d = not_pedaling_q;
    if (win_end) begin
      cadence_d      = edge_q;
      not_pedaling_d = (edge_q < 5'd2);
      edge_d         = cad_rise ? 5'd1 : 5'd0;
    end else if (cad_rise && (edge_q != 5'd31)) begin
      edge_d = edge_q + 5'd1;
    end

    // Current average: weight 1/4 per sample, accumulator holds 4x the mean.
    smp_d      = smp_q + 1'b1;
    smpl       = &smp_q;
    curr_acc_d = curr_acc_q;
    if (smpl) curr_acc_d = curr_acc_q - (curr_acc_q >> 2) + {2'b00, curr};
    avg_curr   = curr_acc_q[13:2];

    // Torque average: weight 1/32 per crank pulse. While idle the accumulator
    // tracks the live torque so pedaling resumes from the present value.
    torq_acc_d = torq_acc_q;
    if (not_pedaling_q)  torq_acc_d = {torque, 5'b00000};
    else if (cad_rise)   torq_acc_d = torq_acc_q - (torq_acc_q >> 5) + {5'b00000, torque};
    avg_torque = torq_acc_q[16:5];

    // Target product, registered into prod_q.
    torque_off = torque_offset(avg_torque);
    incl_fac   = incline_factor(incline);
    cad_fac    = (cadence_q > 5'd1) ? ({1'b0, cadence_q} + 6'd32) : 6'd0;
    prod_d     = 30'(torque_off) * 30'(incl_fac) * 30'(cad_fac) * 30'(scale);

    // Error stage. Low battery bypasses the product pipeline.
    target_curr = target_sat(prod_q);
    batt_low    = (batt < BATT_MIN);
    if (not_pedaling_q || batt_low) error_d = 13'sd0;
    else error_d = $signed({1'b0, target_curr}) - $signed({1'b0, avg_curr});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q         <= '0;
      win_q          <= '0;
      edge_q         <= '0;
      cadence_q      <= '0;
      not_pedaling_q <= 1'b1;
      smp_q          <= '0;
      curr_acc_q     <= '0;
      torq_acc_q     <= '0;
      prod_q         <= '0;
      error_q        <= '0;
    end else begin
      sync_q         <= sync_d;
      win_q          <= win_d;
      edge_q         <= edge_d;
      cadence_q      <= cadence_d;
      not_pedaling_q <= not_pedaling_d;
      smp_q          <= smp_d;
      curr_acc_q     <= curr_acc_d;
      torq_acc_q     <= torq_acc_d;
      prod_q         <= prod_d;
      error_q        <= error_d;
    end
  end

  assign error        = error_q;
  assign not_pedaling = not_pedaling_q;

endmodule

// File: tb/tb_sensor_condition.sv
// tb_sensor_condition
//   Directed bench for sensor_condition with FAST_SIM = 1 (4096-clock cadence
//   window, 256-clock current sample interval). A behavioural model built from
//   integer arithmetic tracks the expected error and not_pedaling every cycle;
//   hand-computed literals at the scenario milestones pin both DUT and model.
module tb_sensor_condition;

  localparam int WIN = 4096;
  localparam int SMP = 256;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cadence_raw = 1'b0;
  logic        [11:0] curr;
  logic        [11:0] torque;
  logic signed [12:0] incline;
  logic        [2:0]  scale;
  logic        [11:0] batt;
  logic signed [12:0] error;
  logic               not_pedaling;

  sensor_condition #(.FAST_SIM(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cadence_raw  (cadence_raw),
    .curr         (curr),
    .torque       (torque),
    .incline      (incline),
    .scale        (scale),
    .batt         (batt),
    .error        (error),
    .not_pedaling (not_pedaling)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Crank pulse generator: within each 4096-cycle frame, pulse_n pulses of
  // period pulse_per starting at pulse_start, 50% duty.
  int pulse_n     = 20;
  int pulse_per   = 200;
  int pulse_start = 100;
  int pcyc        = 0;
  int pf;

  always @(negedge clk) begin
    if (!rst_n) pcyc = 0;
    else        pcyc = pcyc + 1;
    pf = pcyc % WIN;
    if (pf >= pulse_start && ((pf - pulse_start) / pulse_per) < pulse_n &&
        ((pf - pulse_start) % pulse_per) < (pulse_per / 2))
      cadence_raw = 1'b1;
    else
      cadence_raw = 1'b0;
  end

  // Expected target current from averaged torque, incline, cadence, scale.
  function automatic int target_of(input int avg_t, input int incl, input int cad, input int sc);
    int      toff, isat, ifac, cfac, t;
    longint  p;
    toff = avg_t - 896;
    if (toff < 0) toff = 0;
    isat = incl;
    if (isat < -512) isat = -512;
    if (isat > 511)  isat = 511;
    ifac = isat + 256;
    if (ifac < 0)   ifac = 0;
    if (ifac > 511) ifac = 511;
    cfac = (cad > 1) ? cad + 32 : 0;
    p = longint'(toff) * ifac * cfac * sc;
    t = int'(p / 32768);
    if (t > 4095) t = 4095;
    return t;
  endfunction

  // Behavioural model state.
  int m_valid = 0;
  int m_n, m_h1, m_h2, m_h3;
  int m_edges, m_cad, m_np, m_tacc, m_cacc, m_tgt, m_err;
  int m_rise, m_wend, m_smp, n_err, n_tgt, n_tacc, n_cacc, m_incl;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_n = 0; m_h1 = 0; m_h2 = 0; m_h3 = 0;
      m_edges = 0; m_cad = 0; m_np = 1;
      m_tacc = 0; m_cacc = 0; m_tgt = 0; m_err = 0;
      m_valid = 1;
    end else begin
      // A raw edge is seen as a rise three cycles after it is first sampled.
      m_rise = (m_h2 == 1 && m_h3 == 0) ? 1 : 0;
      m_wend = ((m_n % WIN) == WIN - 1) ? 1 : 0;
      m_smp  = ((m_n % SMP) == SMP - 1) ? 1 : 0;
      m_incl = $signed(incline);

      n_err = (m_np == 1 || batt < 12'hA98) ? 0 : m_tgt - m_cacc / 4;
      n_tgt = target_of(m_tacc / 32, m_incl, m_cad, int'(scale));
      if (m_np == 1)       n_tacc = int'(torque) * 32;
      else if (m_rise == 1) n_tacc = m_tacc - m_tacc / 32 + int'(torque);
      else                 n_tacc = m_tacc;
      n_cacc = (m_smp == 1) ? m_cacc - m_cacc / 4 + int'(curr) : m_cacc;

      if (m_wend == 1) begin
        m_cad   = m_edges;
        m_np    = (m_edges < 2) ? 1 : 0;
        m_edges = m_rise;
      end else if (m_rise == 1 && m_edges < 31) begin
        m_edges = m_edges + 1;
      end

      m_err  = n_err;
      m_tgt  = n_tgt;
      m_tacc = n_tacc;
      m_cacc = n_cacc;
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = int'(cadence_raw);
      m_n  = m_n + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid == 1) begin
      check("model_error", error, m_err);
      check("model_not_pedaling", int'(not_pedaling), m_np);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    curr    = 12'h5A5;
    torque  = 12'h7FF;
    incline = 13'h1234;
    scale   = 3'd6;
    batt    = 12'h100;

    // Reset with arbitrary inputs.
    @(negedge clk);
    check("reset_error", error, 0);
    check("reset_not_pedaling", int'(not_pedaling), 1);
    @(negedge clk);
    rst_n   = 1'b1;
    curr    = 12'h000;
    torque  = 12'h480;
    incline = 13'h0000;
    scale   = 3'd4;
    batt    = 12'hC00;

    wait_cycles(4000);
    check("hold_until_window_np", int'(not_pedaling), 1);
    check("hold_until_window_err", error, 0);

    // Nominal: 20 edges per window.
    wait_cycles(2000);
    check("nominal_not_pedaling", int'(not_pedaling), 0);
    check("nominal_error", error, 416);
    check("model_pin_nominal", m_err, 416);

    // Battery low forces zero on the next edge, recovers within 2 cycles.
    batt = 12'hA00;
    @(negedge clk);
    check("batt_low_error", error, 0);
    batt = 12'hC00;
    wait_cycles(2);
    check("batt_restore_error", error, 416);

    // Stop pedaling, then resume.
    pulse_n = 0;
    wait_cycles(2 * WIN + 300);
    check("stop_not_pedaling", int'(not_pedaling), 1);
    check("stop_error", error, 0);
    pulse_n = 20;
    wait_cycles(2 * WIN + 300);
    check("resume_not_pedaling", int'(not_pedaling), 0);
    check("resume_error", error, 416);

    // Closed balance: measured current equals target.
    curr = 12'h1A0;
    wait_cycles(3 * WIN);
    check("balance_error", error, 0);
    check("model_pin_balance", m_err, 0);

    // Saturation: restart from reset with full torque, steep incline, 40 edges.
    rst_n       = 1'b0;
    torque      = 12'hFFF;
    incline     = 13'h0FFF;
    scale       = 3'd7;
    curr        = 12'h000;
    pulse_n     = 40;
    pulse_per   = 100;
    pulse_start = 50;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(WIN + 300);
    check("sat_not_pedaling", int'(not_pedaling), 0);
    check("sat_error", error, 4095);
    check("model_pin_sat", m_err, 4095);

    // Negative extreme: target falls to zero, current at full scale.
    torque = 12'h200;
    curr   = 12'hFFF;
    wait_cycles(4 * WIN);
    check("sat_neg_error", error, -4095);
    check("sat_neg_bits", int'(error[12:0]), 32'h1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
